// File: rtl/dp_ram_pipelined.sv
// Simple-dual-port RAM for the FIFO storage path: byte-lane write port 0,
// read-only port 1 with 1- or 2-cycle read pipeline, selectable
// read-during-write policy and an optional zeroing sweep after reset.
module dp_ram_pipelined #(
  parameter int DATA_RAM_WIDTH = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_WIDTH-1:0]                address_0,
  input  logic                                 chip_enable_0,
  input  logic                                 write_read_0,
  input  logic [DATA_RAM_WIDTH/BYTE_WIDTH-1:0] byte_enable_0,
  input  logic [DATA_RAM_WIDTH-1:0]            data_0,
  input  logic [ADDR_WIDTH-1:0]                address_1,
  input  logic                                 chip_enable_1,
  input  logic                                 write_read_1,
  output logic [DATA_RAM_WIDTH-1:0]            data_1,
  output logic                                 data_1_valid,
  output logic                                 ready
);

  localparam int NUM_BYTES = DATA_RAM_WIDTH / BYTE_WIDTH;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  logic [ADDR_WIDTH-1:0]     r_init_cnt;
  logic                      r_ready;
  logic [DATA_RAM_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                      r_s1_valid;
  logic [DATA_RAM_WIDTH-1:0] r_s1_data;

  logic                      w_init_wr;
  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic                      w_rdw_hit;
  logic [DATA_RAM_WIDTH-1:0] w_rd_old;
  logic [DATA_RAM_WIDTH-1:0] w_rd_data;

  // Replace the enabled byte lanes of old_word with the matching lanes of new_word.
  function automatic logic [DATA_RAM_WIDTH-1:0] lane_merge(
    input logic [DATA_RAM_WIDTH-1:0] old_word,
    input logic [DATA_RAM_WIDTH-1:0] new_word,
    input logic [NUM_BYTES-1:0]      lane_en
  );
    logic [DATA_RAM_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (lane_en[b]) begin
        res[b*BYTE_WIDTH +: BYTE_WIDTH] = new_word[b*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        res[b*BYTE_WIDTH +: BYTE_WIDTH] = old_word[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return res;
  endfunction

  // Request qualification: nothing is accepted while sweeping or on a reset edge.
  always_comb begin
    w_init_wr = rst_n && (r_state == ST_INIT);
    w_wr_acc  = rst_n && r_ready && chip_enable_0 && write_read_0;
    w_rd_acc  = rst_n && r_ready && chip_enable_1 && !write_read_1;
    w_rdw_hit = w_wr_acc && (address_0 == address_1);
  end

  // Read-side data selection: old contents, or same-cycle write merged in when forwarding.
  always_comb begin
    w_rd_old = r_mem[address_1];
    if ((RDW_MODE == 1) && w_rdw_hit) begin
      w_rd_data = lane_merge(w_rd_old, data_0, byte_enable_0);
    end else begin
      w_rd_data = w_rd_old;
    end
  end

  // Init/run state machine: sweep counter stops at the last address, ready registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      r_init_cnt <= '0;
      r_ready    <= (CLEAR_ON_RESET == 0);
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == LAST_ADDR) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
            r_ready    <= 1'b0;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state    <= ST_INIT;
          r_init_cnt <= '0;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zeroing sweep or byte-lane write; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (byte_enable_0[b]) begin
          r_mem[address_0][b*BYTE_WIDTH +: BYTE_WIDTH] <= data_0[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // First read stage: capture the selected word on accept, otherwise hold it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_data;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                      r_s2_valid;
      logic [DATA_RAM_WIDTH-1:0] r_s2_data;

      // Second read stage: forward only valid words so data_1 holds between reads.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign data_1       = r_s2_data;
      assign data_1_valid = r_s2_valid;
    end else begin : g_lat1
      assign data_1       = r_s1_data;
      assign data_1_valid = r_s1_valid;
    end
  endgenerate

  assign ready = r_ready;

endmodule

// File: tb/tb_dp_ram_pipelined.sv
// Scoreboard bench: two RAM instances (latency 1 / old-data, latency 2 /
// forwarded) share one random stimulus stream; a spec-level model pushes
// expected read results with their due cycle, monitors pop and compare.
module tb_dp_ram_pipelined;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BW    = 8;
  localparam int NB    = DW / BW;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] address_0, address_1;
  logic          chip_enable_0, write_read_0, chip_enable_1, write_read_1;
  logic [NB-1:0] byte_enable_0;
  logic [DW-1:0] data_0;
  logic [DW-1:0] data_1_a, data_1_b;
  logic          valid_a, valid_b, ready_a, ready_b;

  dp_ram_pipelined #(.DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
                     .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .address_0(address_0), .chip_enable_0(chip_enable_0), .write_read_0(write_read_0),
    .byte_enable_0(byte_enable_0), .data_0(data_0),
    .address_1(address_1), .chip_enable_1(chip_enable_1), .write_read_1(write_read_1),
    .data_1(data_1_a), .data_1_valid(valid_a), .ready(ready_a)
  );

  dp_ram_pipelined #(.DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
                     .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .address_0(address_0), .chip_enable_0(chip_enable_0), .write_read_0(write_read_0),
    .byte_enable_0(byte_enable_0), .data_0(data_0),
    .address_1(address_1), .chip_enable_1(chip_enable_1), .write_read_1(write_read_1),
    .data_1(data_1_b), .data_1_valid(valid_b), .ready(ready_b)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_hold [2];
  logic [DW-1:0] m_old, m_merged;
  bit            m_ready = 1'b0;
  int            m_cnt = 0;
  int            tick = 0;
  int            vectors = 0;
  int            miscompares = 0;

  // Reference model: reset/sweep timing, read results per instance, array contents.
  always @(posedge clk) begin
    tick = tick + 1;
    if (!rst_n) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      q0.delete();
      q1.delete();
      m_hold[0] = '0;
      m_hold[1] = '0;
    end else if (m_ready) begin
      if (chip_enable_1 && !write_read_1) begin
        m_old    = m_mem[address_1];
        m_merged = m_old;
        if (chip_enable_0 && write_read_0 && (address_0 == address_1)) begin
          for (int b = 0; b < NB; b++)
            if (byte_enable_0[b]) m_merged[b*BW +: BW] = data_0[b*BW +: BW];
        end
        q0.push_back('{m_old, tick});
        q1.push_back('{m_merged, tick + 1});
      end
      if (chip_enable_0 && write_read_0) begin
        for (int b = 0; b < NB; b++)
          if (byte_enable_0[b]) m_mem[address_0][b*BW +: BW] = data_0[b*BW +: BW];
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (m_cnt == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end
  end

  task automatic check_port(input int p, input logic v, input logic [DW-1:0] d);
    exp_t e;
    bit   have;
    bit   due_now;
    have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (p == 0) ? q0[0] : q1[0];
    due_now = have && (e.due == tick);
    vectors++;
    if (v !== due_now) begin
      miscompares++;
      $display("FAIL valid_p%0d cycle %0d: got %b expected %b", p, tick, v, due_now);
    end
    if (due_now) begin
      if (p == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      m_hold[p] = e.data;
    end
    vectors++;
    if (d !== m_hold[p]) begin
      miscompares++;
      $display("FAIL data_p%0d cycle %0d: got %08h expected %08h", p, tick, d, m_hold[p]);
    end
  endtask

  // Monitor: compare both instances away from the active edge.
  always @(posedge clk) begin
    #1;
    check_port(0, valid_a, data_1_a);
    check_port(1, valid_b, data_1_b);
    vectors++;
    if (ready_a !== m_ready || ready_b !== m_ready) begin
      miscompares++;
      $display("FAIL ready cycle %0d: got %b/%b expected %b", tick, ready_a, ready_b, m_ready);
    end
  end

  task automatic drive(input bit ce0, input bit wr0, input logic [NB-1:0] be,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit ce1, input bit wr1, input logic [AW-1:0] a1);
    @(negedge clk);
    chip_enable_0 = ce0; write_read_0 = wr0; byte_enable_0 = be;
    address_0 = a0; data_0 = d0;
    chip_enable_1 = ce1; write_read_1 = wr1; address_1 = a1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1, 4'h0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    drive(1'b1, 1'b1, be, a, d, 1'b0, 1'b1, 4'h0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, a);
  endtask

  initial begin
    rst_n = 1'b0;
    chip_enable_0 = 1'b0; write_read_0 = 1'b0; byte_enable_0 = 4'h0;
    address_0 = 4'h0; data_0 = 32'h0;
    chip_enable_1 = 1'b0; write_read_1 = 1'b1; address_1 = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Requests during the sweep must be ignored.
    wr(4'd3, 32'h0000_00AA, 4'hF);
    rd(4'd3);
    idle(20);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(4);
    // Byte-lane write.
    wr(4'd5, 32'h1122_3344, 4'hF);
    wr(4'd5, 32'hAABB_CCDD, 4'b0101);
    rd(4'd5);
    idle(3);
    // Read latency and hold.
    wr(4'd7, 32'hDEAD_BEEF, 4'hF);
    idle(1);
    rd(4'd7);
    idle(4);
    // Read-during-write collision.
    wr(4'd9, 32'h0000_0000, 4'hF);
    drive(1'b1, 1'b1, 4'b1100, 4'd9, 32'hCAFE_F00D, 1'b1, 1'b0, 4'd9);
    rd(4'd9);
    idle(3);
    // Port no-ops.
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 4'd5);
    drive(1'b1, 1'b0, 4'hF, 4'd5, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'h0);
    rd(4'd5);
    idle(3);
    // Streaming, then reset with reads in flight.
    for (int i = 0; i < 8; i++) wr(AW'(i), 32'h0101_0101 * (i + 1), 4'hF);
    for (int i = 0; i < 8; i++) rd(AW'(i));
    rd(4'd8);
    rd(4'd9);
    @(negedge clk);
    rst_n = 1'b0;
    address_1 = 4'd10;
    @(negedge clk);
    rd(4'd11);
    rst_n = 1'b1;
    idle(20);
    rd(4'd5);
    rd(4'd9);
    idle(3);
    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      logic [AW-1:0] a0, a1;
      a0 = AW'($urandom_range(0, DEPTH - 1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, DEPTH - 1));
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
            NB'($urandom), a0, $urandom,
            bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0), a1);
    end
    idle(5);
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending reads expected 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dp_ram_pipelined.md
# dp_ram_pipelined

Parametrised simple-dual-port RAM that backs the FIFO storage path. It has one write port (port 0) with per-byte write enables and one read-only port (port 1). The read pipeline is selectable at 1 or 2 cycles, with a selectable read-during-write policy. An optional self-clearing init sequencer sweeps the array to zero after reset. Port 0 is driven by the FIFO write side and port 1 by the read side.

## Interface
- DATA_RAM_WIDTH, 32, data width in bits; must be an integer multiple of BYTE_WIDTH
- ADDR_WIDTH, 8, address width; RAM_DEPTH = 2^ADDR_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_RAM_WIDTH/BYTE_WIDTH
- READ_LATENCY, 1, read latency in cycles; legal values are 1 or 2
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new data (forwarded)
- CLEAR_ON_RESET, 1, 1 = zero the array with a sweep after reset; 0 = contents undefined, ready immediately
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge
- address_0  in  ADDR_WIDTH  write address
- chip_enable_0  in  1  port 0 enable
- write_read_0  in  1  1 = write; 0 = no-op (port 0 never reads)
- byte_enable_0  in  NUM_BYTES  per-lane write enable; bit b covers data bits [b*BYTE_WIDTH +: BYTE_WIDTH]
- data_0  in  DATA_RAM_WIDTH  write data
- address_1  in  ADDR_WIDTH  read address
- chip_enable_1  in  1  port 1 enable
- write_read_1  in  1  0 = read; 1 = no-op (port 1 never writes)
- data_1  out  DATA_RAM_WIDTH  read data; holds its last value between reads
- data_1_valid  out  1  one-cycle pulse per accepted read, aligned with data_1
- ready  out  1  high when the array accepts requests (FSM in RUN)

## Operation
- FSM states are INIT and RUN.
  - On reset the FSM enters INIT if CLEAR_ON_RESET=1, otherwise RUN. The init counter resets to 0.
  - In INIT, each cycle writes zero to memory[init_cnt] and increments init_cnt.
  - When init_cnt = RAM_DEPTH-1 the FSM writes that last entry and moves to RUN.
  - RUN persists until the next reset.
- ready = (state == RUN). Its reset value is !CLEAR_ON_RESET.
- While ready=0, all port requests are ignored: no write, no read, and no valid pulse.
- Write is accepted when ready && chip_enable_0 && write_read_0.
  - Lanes with byte_enable_0[b]=1 are updated; other lanes keep their contents.
  - byte_enable_0 = 0 is a legal no-op.
- Read is accepted when ready && chip_enable_1 && !write_read_1. The array is sampled at address_1 on the accept edge.
- Read-during-write occurs when a write and a read are accepted in the same cycle with address_0 == address_1.
  - RDW_MODE=0: the read returns the pre-write contents.
  - RDW_MODE=1: the read returns a per-lane merge. Enabled lanes come from data_0; disabled lanes keep the old contents.
  - Different addresses never interact.
- Port 1 requests with write_read_1=1 are no-ops. Port 0 requests with write_read_0=0 are no-ops.
- Reset asserted mid-operation:
  - All in-flight reads are discarded: data_1=0 and data_1_valid=0 on the reset edge.
  - With CLEAR_ON_RESET=1, the sweep restarts from address 0.
  - With CLEAR_ON_RESET=0, array contents are unaffected by reset.
- Address arithmetic is unsigned and exactly ADDR_WIDTH wide. The init counter stops at RAM_DEPTH-1 and does not wrap.

## Timing
- Reset values: data_1=0, data_1_valid=0, ready=!CLEAR_ON_RESET, state=INIT or RUN as above, init_cnt=0.
- Init duration:
  - The first edge with rst_n=1 clears address 0.
  - ready rises after exactly RAM_DEPTH rising edges with rst_n=1. For ADDR_WIDTH=8 that is 256 edges.
- Write: the array updates on the accept edge. A read accepted on the following edge sees the new data.
- READ_LATENCY=1: data_1 and data_1_valid update on the accept edge and are visible in the next cycle.
- READ_LATENCY=2: there is one extra register stage; data_1 and data_1_valid are visible two cycles after the request cycle.
- Throughput:
  - One write and one read can be accepted per cycle, independently, in both latency modes.
  - Back-to-back reads produce consecutive valid pulses.
- data_1 changes only on cycles where data_1_valid=1, and on reset.

## Test plan
- Init sweep, ADDR_WIDTH=4, CLEAR_ON_RESET=1:
  - Stimulus: hold rst_n=0 for 2 cycles, release, and issue a write of 0xAA to address 3 during INIT.
  - Required: ready rises after 16 edges; the write is ignored; reading addresses 0..15 returns 0 with 16 valid pulses.
- Byte-lane write, starting from 0x11223344 at address 5:
  - Stimulus: write 0xAABBCCDD to address 5 with byte_enable_0=4'b0101, then read address 5.
  - Required: data_1=0x11BB33DD with a one-cycle valid pulse.
- Read latency, READ_LATENCY=1 then 2:
  - Stimulus: read address 7 holding 0xDEADBEEF in cycle N.
  - Required: data_1_valid=1 with data_1=0xDEADBEEF in cycle N+1 or N+2 respectively.
  - Required: data_1 holds that value afterwards with valid=0.
- Read-during-write collision, address 9 holding 0x0, same-cycle write 0xCAFEF00D with byte_enable_0=4'b1100:
  - Required with RDW_MODE=0: read returns 0x00000000.
  - Required with RDW_MODE=1: read returns 0xCAFE0000.
  - Required in both modes: the next read returns 0xCAFE0000.
- Streaming and mid-operation reset:
  - Stimulus: 8 back-to-back reads at READ_LATENCY=2, then assert rst_n with 2 reads in flight.
  - Required: 8 consecutive valid pulses with the correct data.
  - Required on the reset edge: in-flight reads produce no valid pulse, data_1=0, ready=0, and the sweep restarts.
- Port no-ops:
  - Stimulus: chip_enable_1=1 with write_read_1=1; chip_enable_0=1 with write_read_0=0.
  - Required: no valid pulse and the array is unchanged.
